// File: rtl/fc_topk_select_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fc_topk_select_if : logit beat stream into the top-K selector     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface fc_topk_select_if #(
   parameter int IDX_W  = 11,
   parameter int DATA_W = 8
) ();
   logic                     in_valid;
   logic [IDX_W-1:0]         in_class_idx;
   logic signed [DATA_W-1:0] in_logit;
   logic                     in_last;

   modport master (
      output in_valid,
      output in_class_idx,
      output in_logit,
      output in_last
   );

   modport slave (
      input in_valid,
      input in_class_idx,
      input in_logit,
      input in_last
   );
endinterface
`default_nettype wire

// File: rtl/fc_topk_select.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fc_topk_select : keeps a sorted top-K list of streamed logits and  |
// | publishes the ranking at end of stream. Optional: FC_TOPK_CNT_CHECK_EN|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module fc_topk_select #(
   parameter int K           = 5,
   parameter int IDX_W       = 11,
   parameter int DATA_W      = 8,
   parameter int OUT_CLASSES = 1000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   fc_topk_select_if.slave       s_in,
   output logic                  busy,
   output logic                  result_valid,
   output logic [K*IDX_W-1:0]    topk_idx,
   output logic [K*DATA_W-1:0]   topk_logit,
   output logic [3:0]            topk_count,
   output logic                  done
`ifdef FC_TOPK_CNT_CHECK_EN
   ,
   output logic [IDX_W:0]        beat_count,
   output logic                  cnt_err
`endif
);

   localparam logic [IDX_W-1:0]         C_IDX_RST   = '1;
   localparam logic signed [DATA_W-1:0] C_LOGIT_RST = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [3:0]               C_K         = 4'(K);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t                   r_state;
   logic [IDX_W-1:0]         r_idx   [K];
   logic signed [DATA_W-1:0] r_logit [K];
   logic [K-1:0]             r_vld;

   logic [K-1:0]             w_ge;
   logic [IDX_W-1:0]         w_nxt_idx   [K];
   logic signed [DATA_W-1:0] w_nxt_logit [K];
   logic [K-1:0]             w_nxt_vld;
   logic                     w_ins;

   // The list is sorted with valid entries packed at the front, so w_ge is a
   // prefix mask: slot j keeps, takes the beat at the prefix edge, or shifts.
   generate
      for (genvar j = 0; j < K; j++) begin : g_slot
         assign w_ge[j] = r_vld[j] && ($signed(r_logit[j]) >= $signed(s_in.in_logit));
         if (j == 0) begin : g_head
            assign w_nxt_idx[j]   = w_ge[j] ? r_idx[j]   : s_in.in_class_idx;
            assign w_nxt_logit[j] = w_ge[j] ? r_logit[j] : s_in.in_logit;
            assign w_nxt_vld[j]   = 1'b1;
         end else begin : g_body
            assign w_nxt_idx[j]   = w_ge[j]   ? r_idx[j]   :
                                    w_ge[j-1] ? s_in.in_class_idx : r_idx[j-1];
            assign w_nxt_logit[j] = w_ge[j]   ? r_logit[j] :
                                    w_ge[j-1] ? s_in.in_logit     : r_logit[j-1];
            assign w_nxt_vld[j]   = w_ge[j] | w_ge[j-1] | r_vld[j-1];
         end
         assign topk_idx[j*IDX_W +: IDX_W]    = r_idx[j];
         assign topk_logit[j*DATA_W +: DATA_W] = r_logit[j];
      end
   endgenerate

   assign w_ins = !w_ge[K-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_vld        <= '0;
         for (int i = 0; i < K; i++) begin
            r_idx[i]   <= C_IDX_RST;
            r_logit[i] <= C_LOGIT_RST;
         end
         topk_count   <= '0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            // start overrides any beat presented in the same cycle
            r_state      <= S_COLLECT;
            r_vld        <= '0;
            for (int i = 0; i < K; i++) begin
               r_idx[i]   <= C_IDX_RST;
               r_logit[i] <= C_LOGIT_RST;
            end
            topk_count   <= '0;
            busy         <= 1'b1;
            result_valid <= 1'b0;
         end else begin
            case (r_state)
               S_COLLECT: begin
                  if (s_in.in_valid && w_ins) begin
                     for (int i = 0; i < K; i++) begin
                        r_idx[i]   <= w_nxt_idx[i];
                        r_logit[i] <= w_nxt_logit[i];
                     end
                     r_vld <= w_nxt_vld;
                     if (topk_count < C_K) begin
                        topk_count <= topk_count + 4'd1;
                     end
                  end
                  if (s_in.in_last) begin
                     r_state      <= S_DONE;
                     busy         <= 1'b0;
                     result_valid <= 1'b1;
                     done         <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

`ifdef FC_TOPK_CNT_CHECK_EN
   logic [IDX_W:0] w_cnt_nxt;

   assign w_cnt_nxt = (s_in.in_valid && !(&beat_count)) ? beat_count + 1'b1 : beat_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_count <= '0;
         cnt_err    <= 1'b0;
      end else if (start) begin
         beat_count <= '0;
         cnt_err    <= 1'b0;
      end else if (r_state == S_COLLECT) begin
         beat_count <= w_cnt_nxt;
         if (s_in.in_last) begin
            cnt_err <= (w_cnt_nxt != (IDX_W+1)'(OUT_CLASSES));
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: doc/fc_topk_select.md
Name: fc_topk_select

Overview:
- Downstream consumer of the fully connected classifier stage.
- Takes the serial stream of quantized class logits (class index + int8 logit) and keeps a sorted top-K list in registers, updated on the fly.
- When the stream ends, it publishes the final ranked class indices and logits to the host/status interface and pulses done.
- This is the last datapath stage of the MobileNetV1 inference pipeline.

Parameters:
- K, 5, number of top entries kept (1..8).
- IDX_W, 11, class index width.
- DATA_W, 8, signed logit width.
- OUT_CLASSES, 1000, expected number of logits per inference (used by the optional check).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: clear the list and begin collecting
- in_valid  in  1  logit beat valid; one beat accepted per cycle, no backpressure
- in_class_idx  in  IDX_W  class index of the beat
- in_logit  in  DATA_W  signed logit of the beat
- in_last  in  1  marks the final beat; may also be asserted with in_valid=0 (end without data)
- busy  out  1  high in COLLECT
- result_valid  out  1  high in DONE until the next start; top-K outputs stable
- topk_idx  out  K*IDX_W  rank r in bits [r*IDX_W +: IDX_W]; rank 0 is the best
- topk_logit  out  K*DATA_W  rank r in bits [r*DATA_W +: DATA_W], signed
- topk_count  out  4  number of valid entries, saturates at K
- done  out  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all entry valid bits 0.
  - topk_idx all-ones; topk_logit = -2^(DATA_W-1).
  - topk_count, busy, result_valid and done all 0.
- States: IDLE, COLLECT, DONE.
  - IDLE --start--> COLLECT.
  - COLLECT --in_last--> DONE.
  - DONE --start--> COLLECT.
- Clear on start, in any state: valid bits, topk_count and result_valid go to 0; the list returns to reset values; next state is COLLECT. If start and in_valid arrive in the same cycle, start wins and the beat is dropped.
- Insertion (COLLECT, in_valid=1):
  - p = number of valid entries with logit >= in_logit (signed compare).
  - Invalid slots always lose to an incoming beat.
  - If p<K: entries p..K-2 shift to p+1..K-1, the old entry K-1 is discarded, and slot p receives the beat with valid=1.
  - If p==K: the list is unchanged.
- Ties: an existing entry beats a new one, so on equal logits the earlier-arriving (lower-index) class ranks higher.
- Timing: single-cycle update. Outputs reflect a beat on the next rising edge, and back-to-back beats every cycle are supported.
- End of stream: a beat with in_valid=1 and in_last=1 is inserted first. Next cycle the state is DONE, done=1 for exactly one cycle, and result_valid=1 is held.
- in_last with in_valid=0 goes to DONE with the list unchanged, so topk_count can be less than K.
- Beats in IDLE or DONE are ignored, including in_last.
- Reset mid-COLLECT discards all state.
- topk_count increments on each inserted beat while below K and never wraps.
- Indices are stored verbatim; duplicate class indices are not filtered.

Optional Feature:
- Macro: FC_TOPK_CNT_CHECK_EN.
- When defined, the block adds:
  - output beat_count [IDX_W:0]: beats accepted in COLLECT, cleared by start, saturating at all-ones.
  - output cnt_err [1]: set on DONE entry if beat_count != OUT_CLASSES; held until start; reset 0.
- When undefined, neither port exists and there is no counter logic.

Test Plan:
- Ascending stream: start, then 1000 beats with idx=i, logit=(i%256)-128, in_last on i=999 -> topk_logit = {127,127,127,126,126}, topk_idx = {255,511,767,254,510}, topk_count=5, done pulses once.
- Ties: beats (7,+10),(3,+10),(9,+10),(1,+10),(2,+10),(4,+10) with last -> topk_idx = {7,3,9,1,2}; idx 4 is rejected.
- Short stream: beats (5,-3),(6,+4) with in_last on the second -> ranks {6:+4, 5:-3}, topk_count=2, ranks 2..4 hold reset values; a single -128 beat is still inserted.
- Start collision: start in DONE coinciding with in_valid (idx 1, +100) -> list cleared, beat dropped, result_valid=0, busy=1.
- Reset mid-stream: rst_n low after 300 beats -> all outputs at reset values immediately; a new start plus 1000 beats gives the correct top-5.
- With FC_TOPK_CNT_CHECK_EN: 999 beats then in_last -> cnt_err=1, beat_count=999; 1000 beats -> cnt_err=0.
